// File: rtl/ysyx_22040210_pht_sched_pkg.sv
// Shared definitions for the gshare PHT write path: FSM encoding, init value
// and the 2-bit saturating counter step used by both predict and update logic.
package ysyx_22040210_pht_sched_pkg;

  typedef enum logic {
    PHT_INIT = 1'b0,
    PHT_RUN  = 1'b1
  } pht_state_e;

  localparam logic [1:0] PHT_WNT = 2'b01;

  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
    if (taken) sat_cnt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else       sat_cnt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22040210_pht_updq.sv
// Coalescing update queue: index CAM over live entries, FIFO head/tail and count.
// Two enqueue slots per cycle, slot 0 first; slot 1 sees slot 0's effect.
module ysyx_22040210_pht_updq
  import ysyx_22040210_pht_sched_pkg::*;
#(
  parameter int BHRLEN = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    enq0_valid_i,
  input  logic [BHRLEN-1:0]       enq0_idx_i,
  input  logic [1:0]              enq0_cnt_i,
  input  logic                    enq0_taken_i,
  input  logic                    enq1_valid_i,
  input  logic [BHRLEN-1:0]       enq1_idx_i,
  input  logic [1:0]              enq1_cnt_i,
  input  logic                    enq1_taken_i,
  input  logic                    pop_i,
  output logic [BHRLEN-1:0]       head_idx_o,
  output logic [1:0]              head_cnt_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][BHRLEN-1:0] idx_q, idx_d;
  logic [DEPTH-1:0][1:0]        cnt_q, cnt_d;
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [PW:0]                  count_q, count_d;

  logic [1:0]              e_v, e_tk, hit;
  logic [1:0][BHRLEN-1:0]  e_idx;
  logic [1:0][1:0]         e_cnt;
  logic [1:0][PW-1:0]      hpos;
  logic [1:0]              nalloc;

  assign e_v   = {enq1_valid_i, enq0_valid_i};
  assign e_tk  = {enq1_taken_i, enq0_taken_i};
  assign e_idx = {enq1_idx_i, enq0_idx_i};
  assign e_cnt = {enq1_cnt_i, enq0_cnt_i};

  always_comb begin
    vld_d  = vld_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    hit    = '0;
    hpos   = '0;
    nalloc = '0;
    for (int s = 0; s < 2; s++) begin
      // The head leaving this cycle is invisible to the CAM, so a same-index
      // update after it is written separately rather than lost.
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_d[i] && idx_d[i] == e_idx[s] && !(pop_i && PW'(i) == head_q)) begin
          hit[s]  = 1'b1;
          hpos[s] = PW'(i);
        end
      end
      if (e_v[s]) begin
        if (hit[s]) begin
          cnt_d[hpos[s]] = sat_cnt(cnt_d[hpos[s]], e_tk[s]);
        end else begin
          vld_d[tail_d] = 1'b1;
          idx_d[tail_d] = e_idx[s];
          cnt_d[tail_d] = sat_cnt(e_cnt[s], e_tk[s]);
          tail_d        = tail_d + PW'(1);
          nalloc        = nalloc + 2'd1;
        end
      end
    end
    if (pop_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(nalloc) - (PW+1)'(pop_i);
    if (clr_i) begin
      vld_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_idx_o = idx_q[head_q];
  assign head_cnt_o = cnt_q[head_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ysyx_22040210_pht_sched.sv
// PHT write scheduler: init sweep to weakly-not-taken, then drains the
// coalescing update queue onto the single PHT write port.
module ysyx_22040210_pht_sched
  import ysyx_22040210_pht_sched_pkg::*;
#(
  parameter int BHRLEN = 8,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    upd0_valid_i,
  input  logic [PC_W-1:0]         upd0_pc_i,
  input  logic [BHRLEN-1:0]       upd0_bhr_i,
  input  logic [1:0]              upd0_cnt_i,
  input  logic                    upd0_taken_i,
  input  logic                    upd1_valid_i,
  input  logic [PC_W-1:0]         upd1_pc_i,
  input  logic [BHRLEN-1:0]       upd1_bhr_i,
  input  logic [1:0]              upd1_cnt_i,
  input  logic                    upd1_taken_i,
  output logic                    upd_ready_o,
  output logic                    pht_we_o,
  output logic [BHRLEN-1:0]       pht_waddr_o,
  output logic [1:0]              pht_wdata_o,
  output logic                    init_busy_o,
  output logic [$clog2(DEPTH):0]  q_count_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  pht_state_e        state_q, state_d;
  logic [BHRLEN-1:0] ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [BHRLEN-1:0] waddr_q, waddr_d;
  logic [1:0]        wdata_q, wdata_d;

  logic [CW-1:0]     q_count;
  logic [BHRLEN-1:0] head_idx, idx0, idx1;
  logic [1:0]        head_cnt;
  logic              ready, pop, enq0, enq1;
  logic              unused_pc;

  assign idx0 = upd0_pc_i[2 +: BHRLEN] ^ upd0_bhr_i;
  assign idx1 = upd1_pc_i[2 +: BHRLEN] ^ upd1_bhr_i;
  assign unused_pc = ^{upd0_pc_i, upd1_pc_i};

  // Ready depends only on registered state, so valid never loops back to it.
  assign ready = (state_q == PHT_RUN) && ((CW'(DEPTH) - q_count) >= CW'(2));
  assign enq0  = upd0_valid_i && ready && !clr_i;
  assign enq1  = upd1_valid_i && ready && !clr_i;
  assign pop   = (state_q == PHT_RUN) && (q_count != '0) && !clr_i;

  ysyx_22040210_pht_updq #(.BHRLEN(BHRLEN), .DEPTH(DEPTH)) u_updq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr_i),
    .enq0_valid_i (enq0),
    .enq0_idx_i   (idx0),
    .enq0_cnt_i   (upd0_cnt_i),
    .enq0_taken_i (upd0_taken_i),
    .enq1_valid_i (enq1),
    .enq1_idx_i   (idx1),
    .enq1_cnt_i   (upd1_cnt_i),
    .enq1_taken_i (upd1_taken_i),
    .pop_i        (pop),
    .head_idx_o   (head_idx),
    .head_cnt_o   (head_cnt),
    .count_o      (q_count)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (clr_i) begin
      state_d = PHT_INIT;
      ptr_d   = '0;
    end else begin
      case (state_q)
        PHT_INIT: begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = PHT_WNT;
          ptr_d   = ptr_q + BHRLEN'(1);
          if (ptr_q == '1) state_d = PHT_RUN;
        end
        default: begin
          if (pop) begin
            we_d    = 1'b1;
            waddr_d = head_idx;
            wdata_d = head_cnt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PHT_INIT;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign upd_ready_o = ready;
  assign pht_we_o    = we_q;
  assign pht_waddr_o = waddr_q;
  assign pht_wdata_o = wdata_q;
  assign init_busy_o = (state_q == PHT_INIT);
  assign q_count_o   = q_count;

endmodule

// File: tb/tb_ysyx_22040210_pht_sched.sv
// Directed + random bench for the PHT write scheduler against a queue-level model.
module tb_ysyx_22040210_pht_sched;
  localparam int BHRLEN = 4;
  localparam int DEPTH  = 4;
  localparam int NENT   = 1 << BHRLEN;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        v0, v1, tk0, tk1;
  logic [63:0] pc0, pc1;
  logic [3:0]  bhr0, bhr1;
  logic [1:0]  cnt0, cnt1;
  logic        upd_ready, pht_we, init_busy;
  logic [3:0]  pht_waddr;
  logic [1:0]  pht_wdata;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  ysyx_22040210_pht_sched #(.BHRLEN(BHRLEN), .PC_W(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr),
    .upd0_valid_i(v0), .upd0_pc_i(pc0), .upd0_bhr_i(bhr0), .upd0_cnt_i(cnt0), .upd0_taken_i(tk0),
    .upd1_valid_i(v1), .upd1_pc_i(pc1), .upd1_bhr_i(bhr1), .upd1_cnt_i(cnt1), .upd1_taken_i(tk1),
    .upd_ready_o(upd_ready), .pht_we_o(pht_we), .pht_waddr_o(pht_waddr),
    .pht_wdata_o(pht_wdata), .init_busy_o(init_busy), .q_count_o(q_count)
  );

  typedef struct { logic [3:0] idx; logic [1:0] cnt; } ent_t;
  ent_t       mq[$];
  bit         m_init;
  int         m_ptr;
  logic       m_we;
  logic [3:0] m_addr;
  logic [1:0] m_data;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [1:0] ref_sat(input logic [1:0] c, input bit t);
    int n;
    n = t ? int'(c) + 1 : int'(c) - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return 2'(n);
  endfunction

  function automatic logic [3:0] ref_idx(input logic [63:0] pc, input logic [3:0] bhr);
    return 4'((pc >> 2) & 64'hF) ^ bhr;
  endfunction

  function automatic bit m_ready();
    return !m_init && (DEPTH - mq.size()) >= 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_init = 1; m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic m_enq(input logic [3:0] idx, input logic [1:0] c, input bit t, input bit popping);
    int found = -1;
    ent_t e;
    for (int k = (popping ? 1 : 0); k < mq.size(); k++)
      if (mq[k].idx == idx) found = k;
    if (found >= 0) begin
      e = mq[found]; e.cnt = ref_sat(e.cnt, t); mq[found] = e;
    end else begin
      e.idx = idx; e.cnt = ref_sat(c, t); mq.push_back(e);
    end
  endtask

  // One clock of the reference behaviour, using the inputs about to be sampled.
  task automatic model_step();
    bit   popping;
    ent_t h;
    if (clr) begin
      mq.delete(); m_init = 1; m_ptr = 0; m_we = 0;
    end else if (m_init) begin
      m_we = 1; m_addr = 4'(m_ptr); m_data = 2'b01;
      if (m_ptr == NENT - 1) m_init = 0;
      m_ptr = (m_ptr + 1) % NENT;
    end else begin
      popping = mq.size() > 0;
      if (popping) h = mq[0];
      if (v0) m_enq(ref_idx(pc0, bhr0), cnt0, tk0, popping);
      if (v1) m_enq(ref_idx(pc1, bhr1), cnt1, tk1, popping);
      m_we = popping;
      if (popping) begin
        m_addr = h.idx; m_data = h.cnt;
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_we"}, pht_we, m_we);
    if (m_we) begin
      chk({ph, "_waddr"}, pht_waddr, m_addr);
      chk({ph, "_wdata"}, pht_wdata, m_data);
    end
    chk({ph, "_busy"}, init_busy, m_init);
    chk({ph, "_ready"}, upd_ready, m_ready());
    chk({ph, "_qcount"}, q_count, mq.size());
  endtask

  task automatic tick(input string ph);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic idle();
    clr = 0; v0 = 0; v1 = 0; tk0 = 0; tk1 = 0;
    pc0 = '0; pc1 = '0; bhr0 = '0; bhr1 = '0; cnt0 = '0; cnt1 = '0;
  endtask

  task automatic put(input bit s, input logic [63:0] pc, input logic [3:0] bhr,
                     input logic [1:0] c, input bit t);
    if (!s) begin v0 = 1; pc0 = pc; bhr0 = bhr; cnt0 = c; tk0 = t; end
    else    begin v1 = 1; pc1 = pc; bhr1 = bhr; cnt1 = c; tk1 = t; end
  endtask

  task automatic check_reset_vals(input string ph);
    chk({ph, "_we"}, pht_we, 1'b0);
    chk({ph, "_waddr"}, pht_waddr, 4'h0);
    chk({ph, "_wdata"}, pht_wdata, 2'b00);
    chk({ph, "_busy"}, init_busy, 1'b1);
    chk({ph, "_ready"}, upd_ready, 1'b0);
    chk({ph, "_qcount"}, q_count, 3'd0);
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1;

    // Initial sweep: 16 writes of 01, then RUN.
    for (int i = 0; i < NENT; i++) tick("sweep");
    chk("sweep_done_busy", init_busy, 1'b0);
    chk("sweep_done_ready", upd_ready, 1'b1);

    // Single update, index 0x4 ^ 0x3 = 0x7, counter 2 taken -> 3.
    put(0, 64'h8000_0010, 4'h3, 2'd2, 1);
    tick("single_enq");
    idle();
    tick("single_wr");
    chk("single_addr", pht_waddr, 4'h7);
    chk("single_data", pht_wdata, 2'd3);

    // Both slots same index in one cycle: counter stepped twice, one entry.
    put(0, 64'h8000_0010, 4'h3, 2'd1, 1);
    put(1, 64'h8000_0010, 4'h3, 2'd1, 1);
    tick("pair_enq");
    chk("pair_qcount", q_count, 3'd1);
    idle();
    tick("pair_wr");
    chk("pair_data", pht_wdata, 2'd3);
    tick("pair_idle");

    // Fill with distinct indices until ready drops, then drain in order.
    for (int k = 0; k < 3; k++) begin
      idle();
      if (m_ready()) begin
        put(0, 64'h0, 4'(2 * k), 2'(k), 0);
        put(1, 64'h0, 4'(2 * k + 1), 2'(k), 1);
      end
      tick("fill");
    end
    idle();
    repeat (4) tick("drain");

    // Clear with three entries queued: nothing stale may be written.
    for (int k = 0; k < 2; k++) begin
      idle();
      if (m_ready()) begin
        put(0, 64'h0, 4'(8 + 2 * k), 2'd3, 0);
        put(1, 64'h0, 4'(9 + 2 * k), 2'd0, 1);
      end
      tick("refill");
    end
    chk("preclr_qcount", q_count, 3'd3);
    idle();
    clr = 1;
    tick("clr");
    idle();
    for (int i = 0; i < NENT; i++) tick("clr_sweep");
    repeat (4) tick("clr_quiet");

    // Asynchronous reset mid-sweep at ptr=5.
    clr = 1;
    tick("clr2");
    idle();
    repeat (5) tick("pre_rst_sweep");
    #2 rst_n = 0;
    #1 check_reset_vals("async_rst");
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NENT; i++) tick("rst_sweep");

    // Random traffic with heavy index reuse and occasional clears.
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 49) == 0) begin
        clr = 1;
      end else if (m_ready()) begin
        for (int s = 0; s < 2; s++) begin
          if ($urandom_range(0, 9) < 7)
            put(s[0], 64'h8000_0000 | (64'($urandom_range(0, 3)) << 2),
                4'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 15)),
                2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
        end
      end
      tick("rand");
    end
    idle();
    repeat (6) tick("rand_tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
